// File: rtl/matrix_pkg.sv
// Shared definitions for the 2x2 matrix datapath.
//   DATA_W      : width of one result word
//   NUM_RESULTS : words per matrix result (2x2 -> 4)
//   IDX_W       : width of a word index
//   LAST_IDX    : index of the final word of a result set
//   state_t     : unloader state machine encoding
//   result_t    : one result word
package matrix_pkg;

    localparam int DATA_W      = 16;
    localparam int NUM_RESULTS = 4;
    localparam int IDX_W       = $clog2(NUM_RESULTS);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_RESULTS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    typedef logic [DATA_W-1:0] result_t;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector: registers the previous value of a level signal and
// flags the cycle in which it goes from 0 to 1.
//   clk  : system clock, rising edge
//   rst  : asynchronous, active-high reset (previous value cleared to 0)
//   sig  : level input
//   rise : high for one cycle when sig is 1 and was 0 on the previous edge
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic rise
);

    logic sig_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig;
        end
    end

    // A level held high produces exactly one pulse.
    assign rise = sig & ~sig_q;

endmodule

// File: rtl/result_unloader.sv
// Drain side of the 2x2 matrix datapath. Captures the four products when the
// multiplier's done flag rises and streams them out in row-major order over a
// valid/ready handshake.
//   clk, rst            : clock, asynchronous active-high reset
//   multiplication_done : level flag from the multiplier, capture on rise
//   result1..result4    : products R1C1, R1C2, R2C1, R2C2
//   out_data/out_valid/out_ready : word stream, transfer on valid & ready
//   out_index           : position (0..3) of out_data
//   out_last            : high with the final word (index 3)
//   busy                : a captured set is not yet fully drained
//   overrun             : sticky, a set arrived while busy and was dropped
//   clear_overrun       : synchronous clear of overrun (a new event wins)
module result_unloader
    import matrix_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              multiplication_done,
    input  logic [DATA_W-1:0] result1,
    input  logic [DATA_W-1:0] result2,
    input  logic [DATA_W-1:0] result3,
    input  logic [DATA_W-1:0] result4,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  out_index,
    output logic              out_last,
    output logic              busy,
    output logic              overrun,
    input  logic              clear_overrun
);

    state_t           state;
    logic [IDX_W-1:0] index;
    result_t          hold [NUM_RESULTS];
    logic             valid_q;
    logic             busy_q;
    logic             overrun_q;

    logic done_rise;
    logic xfer;
    logic last_xfer;
    logic drop;

    rise_detect u_done_rise (
        .clk  (clk),
        .rst  (rst),
        .sig  (multiplication_done),
        .rise (done_rise)
    );

    assign xfer      = valid_q & out_ready;
    assign last_xfer = xfer & (index == LAST_IDX);
    // A new set can only be taken in IDLE or on the final transfer; any
    // other rise while sending is dropped and flagged.
    assign drop      = (state == SEND) & done_rise & ~last_xfer;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            index     <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
            for (int i = 0; i < NUM_RESULTS; i++) begin
                hold[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (done_rise) begin
                        hold[0] <= result1;
                        hold[1] <= result2;
                        hold[2] <= result3;
                        hold[3] <= result4;
                        index   <= '0;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state   <= SEND;
                    end
                end
                SEND: begin
                    if (last_xfer) begin
                        index <= '0;
                        if (done_rise) begin
                            // Back-to-back set: keep valid high, no bubble.
                            hold[0] <= result1;
                            hold[1] <= result2;
                            hold[2] <= result3;
                            hold[3] <= result4;
                        end else begin
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            state   <= IDLE;
                        end
                    end else if (xfer) begin
                        index <= index + IDX_W'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    index   <= '0;
                end
            endcase

            if (drop) begin
                overrun_q <= 1'b1;
            end else if (clear_overrun) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign out_data  = hold[index];
    assign out_index = index;
    assign out_last  = valid_q & (index == LAST_IDX);
    assign out_valid = valid_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_result_unloader.sv
// Testbench for result_unloader: directed scenarios followed by random traffic,
// all checked against a queue-based reference model of the drain behaviour.
module tb_result_unloader;

    logic        clk = 1'b0;
    logic        rst;
    logic        multiplication_done;
    logic [15:0] result1, result2, result3, result4;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_index;
    logic        out_last;
    logic        busy;
    logic        overrun;
    logic        clear_overrun;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: words still owed to the consumer, head is current.
    logic [15:0] mq [$];
    logic        m_ovr;
    logic        m_prev_done;
    logic [15:0] xlog [$];

    always #5 clk = ~clk;

    result_unloader dut (
        .clk                 (clk),
        .rst                 (rst),
        .multiplication_done (multiplication_done),
        .result1             (result1),
        .result2             (result2),
        .result3             (result3),
        .result4             (result4),
        .out_data            (out_data),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .out_index           (out_index),
        .out_last            (out_last),
        .busy                (busy),
        .overrun             (overrun),
        .clear_overrun       (clear_overrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovr       = 1'b0;
        m_prev_done = 1'b0;
    endtask

    // Applies the rules at one rising edge using the inputs present there.
    task automatic model_edge();
        bit rise;
        bit set;
        if (rst) return;
        rise = multiplication_done && !m_prev_done;
        if (mq.size() > 0 && out_ready) void'(mq.pop_front());
        set = 1'b0;
        if (rise) begin
            if (mq.size() == 0) begin
                mq.push_back(result1);
                mq.push_back(result2);
                mq.push_back(result3);
                mq.push_back(result4);
            end else begin
                set = 1'b1;
            end
        end
        if (set) m_ovr = 1'b1;
        else if (clear_overrun) m_ovr = 1'b0;
        m_prev_done = multiplication_done;
    endtask

    task automatic check_outputs();
        bit ev;
        ev = (mq.size() > 0);
        chk("valid", out_valid, ev);
        chk("busy", busy, ev);
        chk("overrun", overrun, m_ovr);
        if (ev) begin
            chk("data", out_data, mq[0]);
            chk("index", out_index, 4 - mq.size());
            chk("last", out_last, mq.size() == 1);
        end else begin
            chk("idle_index", out_index, 0);
            chk("idle_last", out_last, 0);
        end
        if (out_valid && out_ready) xlog.push_back(out_data);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic set_results(input logic [15:0] a, b, c, d);
        result1 = a; result2 = b; result3 = c; result4 = d;
    endtask

    task automatic pulse_done();
        multiplication_done = 1'b1;
        step();
        multiplication_done = 1'b0;
    endtask

    // Steps until the model holds the given number of words, bounded.
    task automatic wait_size(input int sz);
        int guard = 0;
        while (mq.size() != sz && guard < 40) begin
            step();
            guard++;
        end
        if (mq.size() != sz) chk("wait_timeout", 0, 1);
    endtask

    initial begin
        rst = 1'b1;
        multiplication_done = 1'b0;
        out_ready = 1'b0;
        clear_overrun = 1'b0;
        set_results(16'd0, 16'd0, 16'd0, 16'd0);
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        rst = 1'b0;
        step();

        // Basic drain
        xlog.delete();
        out_ready = 1'b1;
        set_results(16'd11, 16'd25, 16'd44, 16'd100);
        pulse_done();
        chk("s1_first_valid", out_valid, 1);
        repeat (6) step();
        chk("s1_count", xlog.size(), 4);
        if (xlog.size() == 4) begin
            chk("s1_w0", xlog[0], 11);
            chk("s1_w1", xlog[1], 25);
            chk("s1_w2", xlog[2], 44);
            chk("s1_w3", xlog[3], 100);
        end
        chk("s1_busy_end", busy, 0);

        // Backpressure at index 1
        xlog.delete();
        pulse_done();
        wait_size(3);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("s2_stall_data", out_data, 25);
            chk("s2_stall_index", out_index, 1);
        end
        out_ready = 1'b1;
        repeat (5) step();
        chk("s2_count", xlog.size(), 4);
        if (xlog.size() == 4) chk("s2_w3", xlog[3], 100);

        // Level done held high
        xlog.delete();
        multiplication_done = 1'b1;
        repeat (20) step();
        multiplication_done = 1'b0;
        repeat (2) step();
        chk("s3_transfers", xlog.size(), 4);
        chk("s3_overrun", overrun, 0);

        // Overrun at index 2
        xlog.delete();
        pulse_done();
        wait_size(2);
        set_results(16'd1, 16'd2, 16'd3, 16'd4);
        pulse_done();
        repeat (4) step();
        chk("s4_count", xlog.size(), 4);
        if (xlog.size() == 4) begin
            chk("s4_w2", xlog[2], 44);
            chk("s4_w3", xlog[3], 100);
        end
        chk("s4_overrun", overrun, 1);
        repeat (3) step();
        chk("s4_overrun_sticky", overrun, 1);
        clear_overrun = 1'b1;
        step();
        clear_overrun = 1'b0;
        chk("s4_overrun_clr", overrun, 0);

        // Back-to-back capture on the final transfer
        set_results(16'd11, 16'd25, 16'd44, 16'd100);
        pulse_done();
        wait_size(1);
        set_results(16'd501, 16'd502, 16'd503, 16'd504);
        pulse_done();
        chk("s5_no_gap", out_valid, 1);
        chk("s5_new_r1c1", out_data, 501);
        chk("s5_index0", out_index, 0);
        chk("s5_overrun", overrun, 0);
        repeat (6) step();

        // Asynchronous reset mid-stream
        set_results(16'd11, 16'd25, 16'd44, 16'd100);
        pulse_done();
        wait_size(3);
        #2 rst = 1'b1;
        #1;
        chk("s6_valid", out_valid, 0);
        chk("s6_data", out_data, 0);
        chk("s6_index", out_index, 0);
        chk("s6_last", out_last, 0);
        chk("s6_busy", busy, 0);
        chk("s6_overrun", overrun, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step();
        xlog.delete();
        pulse_done();
        chk("s6_restart_index", out_index, 0);
        repeat (6) step();
        chk("s6_restart_count", xlog.size(), 4);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) multiplication_done = ~multiplication_done;
            out_ready     = ($urandom_range(0, 2) != 0);
            clear_overrun = ($urandom_range(0, 15) == 0);
            set_results(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
